// File: rtl/mux16_1_pkg.sv
// Shared widths and word types for the register-file read multiplexers.
// Package name is mux_pkg; it is imported by mux2_1, mux16_1_if and mux16_1.
package mux_pkg;

  localparam int WORD_W = 64;
  localparam int SEL_W  = 4;
  localparam int NUM_IN = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [NUM_IN-1:0] word16_t;

endpackage

// File: rtl/mux16_1_if.sv
// Read-port bundle of the 16:1 word multiplexer: data words, select and result.
// There is no handshake; the result follows i[sel] (combinationally, or one
// clock later when MUX16_1_OUT_REG_EN is defined).
interface mux16_1_if;
  import mux_pkg::*;

  word16_t            i;
  logic [SEL_W-1:0]   sel;
  word_t              out;

  // master drives the data and select, slave returns the selected word
  modport master (output i, output sel, input out);
  modport slave  (input i, input sel, output out);

endinterface

// File: rtl/mux2_1.sv
// 64-bit 2:1 word multiplexer; leaf cell of the 16:1 tree and of the
// 32-register read-port combining stage.
module mux2_1
  import mux_pkg::*;
(
  input  word_t i0,
  input  word_t i1,
  input  logic  sel,
  output word_t out
);

  // one select drives every bit of the word
  assign out = sel ? i1 : i0;

endmodule

// File: rtl/mux16_1.sv
// 64-bit 16:1 word multiplexer built as a four-level binary tree of mux2_1.
// Optional feature macro: MUX16_1_OUT_REG_EN adds a 64-bit output register
// with asynchronous active-high clear (one-cycle read latency). Without the
// macro the block is purely combinational and clk/reset are unused.
module mux16_1
  import mux_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  mux16_1_if.slave   bus
);

  word_t lvl0 [8];
  word_t lvl1 [4];
  word_t lvl2 [2];
  word_t tree_out;

  // level 0: pairs i[2k] / i[2k+1] on sel[0]
  for (genvar k = 0; k < 8; k++) begin : g_lvl0
    mux2_1 u_mux (
      .i0  (bus.i[2*k]),
      .i1  (bus.i[2*k+1]),
      .sel (bus.sel[0]),
      .out (lvl0[k])
    );
  end

  // level 1: sel[1]
  for (genvar k = 0; k < 4; k++) begin : g_lvl1
    mux2_1 u_mux (
      .i0  (lvl0[2*k]),
      .i1  (lvl0[2*k+1]),
      .sel (bus.sel[1]),
      .out (lvl1[k])
    );
  end

  // level 2: sel[2]
  for (genvar k = 0; k < 2; k++) begin : g_lvl2
    mux2_1 u_mux (
      .i0  (lvl1[2*k]),
      .i1  (lvl1[2*k+1]),
      .sel (bus.sel[2]),
      .out (lvl2[k])
    );
  end

  // level 3: root cell on sel[3]
  mux2_1 u_root (
    .i0  (lvl2[0]),
    .i1  (lvl2[1]),
    .sel (bus.sel[3]),
    .out (tree_out)
  );

`ifdef MUX16_1_OUT_REG_EN
  word_t out_q;

  // capture the tree result each rising edge; reset clears it immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset) out_q <= '0;
    else       out_q <= tree_out;
  end

  assign bus.out = out_q;
`else
  // clock and reset are kept on the port list so parents are build-agnostic
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, clk, reset};

  assign bus.out = tree_out;
`endif

endmodule

// File: tb/tb_mux16_1.sv
// Scoreboard bench for mux16_1: drivers push expected words into exp_q and
// raise chk_ev at the sampling point; the monitor pops and compares.
// Covers both builds; MUX16_1_OUT_REG_EN enables the registered scenarios.
module tb_mux16_1;
  import mux_pkg::*;

  logic clk;
  logic reset;

  mux16_1_if bus_a ();
  mux16_1_if bus_lo ();
  mux16_1_if bus_hi ();

  logic [4:0] psel;
  word_t      par_out;

  mux16_1 dut (.clk(clk), .reset(reset), .bus(bus_a));

  // 32-entry read port: two banks combined by one 2:1 stage
  mux16_1 u_lo (.clk(clk), .reset(reset), .bus(bus_lo));
  mux16_1 u_hi (.clk(clk), .reset(reset), .bus(bus_hi));
  mux2_1  u_top (.i0(bus_lo.out), .i1(bus_hi.out), .sel(psel[4]), .out(par_out));

  assign bus_lo.sel = psel[3:0];
  assign bus_hi.sel = psel[3:0];

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // scoreboard state
  logic [WORD_W-1:0] exp_q[$];
  string             name_q[$];
  bit                src_q[$];
  int                checks = 0;
  int                errors = 0;
  event              chk_ev;

  word_t data_tab [16];
  word_t exp_sweep [16];
  word_t hi_tab [16];

  // monitor: pops one expectation per sample strobe
  initial begin
    forever begin
      word_t act;
      word_t e;
      string nm;
      bit    s;
      @(chk_ev);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: strobe with no expected value");
      end else begin
        e   = exp_q.pop_front();
        nm  = name_q.pop_front();
        s   = src_q.pop_front();
        act = s ? par_out : bus_a.out;
        if (act !== e) begin
          errors++;
          $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, act, act, e, e);
        end
      end
    end
  end

  // push an expectation and strobe the monitor now
  task automatic expect_now(input word_t e, input string nm, input bit s);
    exp_q.push_back(e);
    name_q.push_back(nm);
    src_q.push_back(s);
    ->chk_ev;
    #1;
  endtask

  // wait for the result of the inputs just driven to become visible
  task automatic settle();
`ifdef MUX16_1_OUT_REG_EN
    @(posedge clk);
    #1;
`else
    #10;
`endif
  endtask

  // driver: change select on the main instance, then check
  task automatic apply_sel(input logic [3:0] s, input word_t e, input string nm);
`ifdef MUX16_1_OUT_REG_EN
    @(negedge clk);
`endif
    bus_a.sel = s;
    settle();
    expect_now(e, nm, 1'b0);
  endtask

  // driver: change one data word on the main instance, then check
  task automatic apply_word(input int k, input word_t v, input word_t e, input string nm);
`ifdef MUX16_1_OUT_REG_EN
    @(negedge clk);
`endif
    bus_a.i[k] = v;
    settle();
    expect_now(e, nm, 1'b0);
  endtask

  // driver: change the 5-bit select of the 32-entry parent
  task automatic apply_par(input logic [4:0] s, input word_t e, input string nm);
`ifdef MUX16_1_OUT_REG_EN
    @(negedge clk);
`endif
    psel = s;
    settle();
    expect_now(e, nm, 1'b1);
  endtask

  // watchdog
  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    data_tab  = '{64'd64357, 64'd26000, 64'd24556, 64'd12328, 64'd63, 64'd31,
                  64'd132346, 64'd7, 64'd157, 64'd2803, 64'd308, 64'd64,
                  64'd27, 64'd879, 64'd538129, 64'd1327};
    exp_sweep = '{64'd64357, 64'd26000, 64'd24556, 64'd12328, 64'd63, 64'd31,
                  64'd132346, 64'd7, 64'd157, 64'd2803, 64'd308, 64'd64,
                  64'd27, 64'd879, 64'd538129, 64'd1327};
    hi_tab    = '{64'd257, 64'd258, 64'd259, 64'd260, 64'd261, 64'd262, 64'd263,
                  64'd264, 64'd264, 64'd265, 64'd266, 64'd267, 64'd268, 64'd269,
                  64'd270, 64'd271};

    reset = 1'b1;
    bus_a.sel = '0;
    psel = '0;
    for (int k = 0; k < 16; k++) begin
      bus_a.i[k]  = data_tab[k];
      bus_lo.i[k] = data_tab[k];
      bus_hi.i[k] = hi_tab[k];
    end
    #12;
`ifdef MUX16_1_OUT_REG_EN
    expect_now(64'd0, "reset_state", 1'b0);
`endif
    reset = 1'b0;

    // 1: select sweep
    for (int s = 0; s < 16; s++)
      apply_sel(s[3:0], exp_sweep[s], $sformatf("sweep_sel%0d", s));

    // 2: full-width check
    for (int k = 0; k < 16; k++) bus_a.i[k] = '0;
    bus_a.i[5] = 64'hFFFF_FFFF_FFFF_FFFF;
    apply_sel(4'd5, 64'hFFFF_FFFF_FFFF_FFFF, "width_sel5_ones");
    apply_sel(4'd4, 64'h0, "width_sel4_zero");

    // 3: data changes under a fixed select
    for (int k = 0; k < 16; k++) bus_a.i[k] = data_tab[k];
    apply_sel(4'd14, 64'd538129, "fixed_sel14");
    apply_word(14, 64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, "follow_i14");
    apply_word(13, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0001, "ignore_i13");
    bus_a.i[14] = data_tab[14];
    bus_a.i[13] = data_tab[13];

`ifdef MUX16_1_OUT_REG_EN
    // 4: asynchronous reset mid-cycle
    apply_sel(4'd1, 64'd26000, "pre_reset_sel1");
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    expect_now(64'd0, "reset_async_clear", 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    expect_now(64'd0, "reset_hold_until_edge", 1'b0);
    @(posedge clk);
    #1;
    expect_now(64'd26000, "reset_first_edge", 1'b0);

    // 5: one-cycle latency
    apply_sel(4'd2, 64'd24556, "latency_sel2");
    @(negedge clk);
    bus_a.sel = 4'd3;
    #1;
    expect_now(64'd24556, "latency_before_edge", 1'b0);
    @(posedge clk);
    #1;
    expect_now(64'd12328, "latency_after_edge", 1'b0);
`endif

    // 6: 32-entry parent integration
    for (int s = 0; s < 32; s++)
      apply_par(s[4:0], (s < 16) ? exp_sweep[s] : hi_tab[s-16],
                $sformatf("parent_sel%0d", s));
    apply_par(5'd16, 64'd257, "parent_sel16_point");
    apply_par(5'd31, 64'd271, "parent_sel31_point");
    apply_par(5'd24, 64'd264, "parent_dup264");

    #5;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
